row_stream_gen: RTL and testbench

Producer side of the row-accumulation datapath. It loads one input vector of `N` 64-bit field elements over a valid/ready handshake, then streams it `ROWS` times back-to-back. Each element is paired with a shift exponent `w = (r*c*STEP) mod WMOD`, so the downstream shift/mod-reduce/accumulate row calculator receives a contiguous, frame-aligned `a`/`w` stream with no backpressure.

---
 rtl/rowcalc_pkg.sv | 27 ++
 rtl/twiddle_exp_acc.sv | 39 +++
 rtl/row_stream_gen.sv | 151 +++++++++++++++
 tb/tb_row_stream_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rowcalc_pkg.sv
// Shared widths, defaults, FSM states and modular-add helper for the row-accumulation datapath.
package rowcalc_pkg;

  localparam int DATA_W   = 64;
  localparam int EXP_W    = 8;
  localparam int N_DEF    = 72;
  localparam int ROWS_DEF = 72;
  localparam int STEP_DEF = 8;
  localparam int WMOD_DEF = 192;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_PRIME,
    ST_STREAM
  } state_t;

  // (a + b) mod m for a, b < m <= 256: one add, one conditional subtract.
  function automatic logic [EXP_W-1:0] mod_add(input logic [EXP_W-1:0] a,
                                               input logic [EXP_W-1:0] b,
                                               input logic [EXP_W:0]   m);
    logic [EXP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= m) s = s - m;
    return s[EXP_W-1:0];
  endfunction

endpackage

// File: rtl/twiddle_exp_acc.sv
// Incremental shift-exponent generator: wexp walks r*c*STEP mod WMOD using adds only.
// Update on the edge after a strobe; clear has priority over row_step over col_step.
module twiddle_exp_acc
  import rowcalc_pkg::*;
#(
  parameter int STEP = STEP_DEF,
  parameter int WMOD = WMOD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             col_step,
  input  logic             row_step,
  output logic [EXP_W-1:0] wexp
);

  localparam int MW = EXP_W + 1;
  localparam logic [EXP_W:0]   MOD    = MW'(WMOD);
  localparam logic [EXP_W-1:0] STEP_V = EXP_W'(STEP);

  // delta is the per-column increment for the current row, i.e. r*STEP mod WMOD.
  logic [EXP_W-1:0] delta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta <= '0;
      wexp  <= '0;
    end else if (clear) begin
      delta <= '0;
      wexp  <= '0;
    end else if (row_step) begin
      wexp  <= '0;
      delta <= mod_add(delta, STEP_V, MOD);
    end else if (col_step) begin
      wexp  <= mod_add(wexp, delta, MOD);
    end
  end

endmodule

// File: rtl/row_stream_gen.sv
// Loads N words, then streams them ROWS times with exponent (r*c*STEP) mod WMOD; first output 2 cycles after last load.
// Output has no backpressure; in_ready only in LOAD. ROWSTREAM_REPLAY_EN adds a replay input to re-stream the buffer.
module row_stream_gen
  import rowcalc_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int STEP = STEP_DEF,
  parameter int WMOD = WMOD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef ROWSTREAM_REPLAY_EN
  input  logic              replay,
`endif
  output logic [DATA_W-1:0] a_out,
  output logic [EXP_W-1:0]  w_out,
  output logic              out_valid,
  output logic              sof,
  output logic              eof,
  output logic [7:0]        row_idx,
  output logic              done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(ROWS + 1);

  state_t            state, state_n;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     c;
  logic [RW-1:0]     r;
  logic [DATA_W-1:0] mem [N];
  logic [EXP_W-1:0]  wexp;

  logic accept, start_replay, last_col, stream_done;
  logic acc_clear, acc_col, acc_row;

`ifdef ROWSTREAM_REPLAY_EN
  logic loaded;
  assign start_replay = (state == ST_LOAD) && replay && loaded && (wr_cnt == '0);
`else
  assign start_replay = 1'b0;
`endif

  assign accept      = (state == ST_LOAD) && in_ready && in_valid && !start_replay;
  assign last_col    = (c == CW'(N - 1));
  // r runs one past the last row so the edge after the final element can emit done.
  assign stream_done = (r == RW'(ROWS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    acc_clear = 1'b0;
    acc_col   = 1'b0;
    acc_row   = 1'b0;
    case (state)
      ST_LOAD: begin
        if (start_replay || (accept && wr_cnt == CW'(N - 1))) state_n = ST_PRIME;
      end
      ST_PRIME: begin
        acc_clear = 1'b1;
        state_n   = ST_STREAM;
      end
      ST_STREAM: begin
        if (stream_done) begin
          state_n = ST_LOAD;
        end else begin
          acc_col = !last_col;
          acc_row = last_col;
        end
      end
      default: state_n = ST_LOAD;
    endcase
  end

  twiddle_exp_acc #(.STEP(STEP), .WMOD(WMOD)) u_exp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .col_step (acc_col),
    .row_step (acc_row),
    .wexp     (wexp)
  );

  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      c         <= '0;
      r         <= '0;
      in_ready  <= 1'b0;
      a_out     <= '0;
      w_out     <= '0;
      out_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else begin
      in_ready  <= (state_n == ST_LOAD);
      out_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      done      <= 1'b0;
      if (accept) wr_cnt <= (wr_cnt == CW'(N - 1)) ? '0 : wr_cnt + 1'b1;
      case (state)
        ST_PRIME: begin
          c <= '0;
          r <= '0;
        end
        ST_STREAM: begin
          if (stream_done) begin
            done <= 1'b1;
          end else begin
            a_out     <= mem[c];
            w_out     <= wexp;
            out_valid <= 1'b1;
            sof       <= (c == '0);
            eof       <= last_col;
            row_idx   <= 8'(r);
            if (last_col) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROWSTREAM_REPLAY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      loaded <= 1'b0;
    else if (accept && wr_cnt == CW'(N - 1))         loaded <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_row_stream_gen.sv
// Bench for row_stream_gen: 4x3 instances (STEP 8 and STEP 100) and a default 72x72 instance.
module tb_row_stream_gen;

  typedef logic [63:0] vec4_t [4];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid_d = 1'b0;
  logic [63:0] in_data = '0;
`ifdef ROWSTREAM_REPLAY_EN
  logic        replay = 1'b0;
  logic        replay_d = 1'b0;
`endif

  logic        s_in_ready, s_out_valid, s_sof, s_eof, s_done;
  logic [63:0] s_a_out;
  logic [7:0]  s_w_out, s_row_idx;
  logic        x_in_ready, x_out_valid, x_sof, x_eof, x_done;
  logic [63:0] x_a_out;
  logic [7:0]  x_w_out, x_row_idx;
  logic        d_in_ready, d_out_valid, d_sof, d_eof, d_done;
  logic [63:0] d_a_out;
  logic [7:0]  d_w_out, d_row_idx;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  vec4_t cur;
  logic [63:0] dvec [72];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  row_stream_gen #(.N(4), .ROWS(3), .STEP(8), .WMOD(192)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
`ifdef ROWSTREAM_REPLAY_EN
    .replay(replay),
`endif
    .a_out(s_a_out), .w_out(s_w_out), .out_valid(s_out_valid), .sof(s_sof), .eof(s_eof),
    .row_idx(s_row_idx), .done(s_done));

  row_stream_gen #(.N(4), .ROWS(3), .STEP(100), .WMOD(192)) dut_x (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready), .in_data(in_data),
`ifdef ROWSTREAM_REPLAY_EN
    .replay(replay),
`endif
    .a_out(x_a_out), .w_out(x_w_out), .out_valid(x_out_valid), .sof(x_sof), .eof(x_eof),
    .row_idx(x_row_idx), .done(x_done));

  row_stream_gen dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(d_in_ready), .in_data(in_data),
`ifdef ROWSTREAM_REPLAY_EN
    .replay(replay_d),
`endif
    .a_out(d_a_out), .w_out(d_w_out), .out_valid(d_out_valid), .sof(d_sof), .eof(d_eof),
    .row_idx(d_row_idx), .done(d_done));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec(output vec4_t v);
    for (int i = 0; i < 4; i++) v[i] = {$urandom, $urandom};
  endtask

  task automatic load_small(input vec4_t v, input bit throttle, output int hs);
    int  i;
    int  guard;
    logic take;
    i = 0;
    guard = 0;
    hs = -10;
    while (i < 4 && guard < 100) begin
      in_valid = throttle ? ((guard % 2) == 0) : 1'b1;
      in_data  = v[i];
      take     = in_valid && s_in_ready;
      tick();
      guard++;
      if (take) begin
        i++;
        hs = cyc;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (i != 4) begin
      errors++;
      $display("FAIL load_count: accepted %0d words, required 4", i);
    end
  endtask

  // Reference: a = v[c], w = (r*c*STEP) mod 192, 12 contiguous outputs, then a done pulse.
  task automatic check_stream(input vec4_t v, input int hs, input bit hold_valid);
    int guard;
    int r, c;
    logic [83:0] exp_s, act_s;
    logic [72:0] exp_x, act_x;
    guard = 0;
    in_valid = hold_valid;
    in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    while (!s_out_valid && guard < 8) begin
      tick();
      guard++;
    end
    checks++;
    if (!s_out_valid || cyc != hs + 2) begin
      errors++;
      $display("FAIL first_out_latency: out_valid=%0b at cycle %0d, required 1 at cycle %0d",
               s_out_valid, cyc, hs + 2);
    end
    for (int k = 0; k < 12; k++) begin
      r = k / 4;
      c = k % 4;
      exp_s = {1'b1, v[c], 8'((r * c * 8) % 192), c == 0, c == 3, 8'(r), 1'b0};
      act_s = {s_out_valid, s_a_out, s_w_out, s_sof, s_eof, s_row_idx, s_done};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL stream_elem r=%0d c=%0d: got %h, required %h", r, c, act_s, exp_s);
      end
      exp_x = {1'b1, v[c], 8'((r * c * 100) % 192)};
      act_x = {x_out_valid, x_a_out, x_w_out};
      checks++;
      if (act_x !== exp_x) begin
        errors++;
        $display("FAIL wrap_elem r=%0d c=%0d: got %h, required %h", r, c, act_x, exp_x);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({s_done, s_out_valid, s_in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL done_cycle: done/out_valid/in_ready=%b, required 101",
               {s_done, s_out_valid, s_in_ready});
    end
    tick();
    checks++;
    if ({s_done, s_out_valid, s_in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL done_pulse: done/out_valid/in_ready=%b, required 001",
               {s_done, s_out_valid, s_in_ready});
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_in_ready, s_out_valid, s_sof, s_eof, s_done, s_a_out, s_w_out, s_row_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {s_in_ready, s_out_valid, s_sof, s_eof, s_done, s_a_out, s_w_out, s_row_idx});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b, required 0", s_in_ready);
    end
    tick();
    checks++;
    if ({s_in_ready, d_in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_release: in_ready s/d=%b, required 11", {s_in_ready, d_in_ready});
    end
  endtask

  task automatic test_basic;
    vec4_t v;
    int hs;
    v = '{64'd1, 64'd2, 64'd3, 64'd4};
    load_small(v, 1'b0, hs);
    check_stream(v, hs, 1'b0);
    cur = v;
  endtask

  task automatic test_throttle;
    vec4_t v;
    int hs;
    rand_vec(v);
    load_small(v, 1'b1, hs);
    check_stream(v, hs, 1'b1);
    cur = v;
  endtask

  task automatic test_random;
    vec4_t v;
    int hs;
    for (int n = 0; n < 3; n++) begin
      rand_vec(v);
      load_small(v, ($urandom % 2) == 1, hs);
      check_stream(v, hs, ($urandom % 2) == 1);
      cur = v;
    end
  endtask

  task automatic test_reset_mid;
    vec4_t v;
    int hs;
    int guard;
    rand_vec(v);
    load_small(v, 1'b0, hs);
    guard = 0;
    while (!s_out_valid && guard < 8) begin
      tick();
      guard++;
    end
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_in_ready, s_out_valid, s_sof, s_eof, s_done, s_a_out, s_w_out, s_row_idx,
         x_out_valid, x_a_out, x_w_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: s a=%h w=%h vld=%b rdy=%b, x a=%h w=%h, required all 0",
               s_a_out, s_w_out, s_out_valid, s_in_ready, x_a_out, x_w_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: in_ready=%b, required 1", s_in_ready);
    end
    rand_vec(v);
    load_small(v, 1'b0, hs);
    check_stream(v, hs, 1'b0);
    cur = v;
  endtask

`ifdef ROWSTREAM_REPLAY_EN
  task automatic test_replay;
    vec4_t v;
    int hs;
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL replay_ready: in_ready=%b, required 1", s_in_ready);
    end
    replay   = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h77;
    tick();
    hs = cyc;
    replay   = 1'b0;
    in_valid = 1'b0;
    check_stream(cur, hs, 1'b0);
    rand_vec(v);
    load_small(v, 1'b0, hs);
    check_stream(v, hs, 1'b0);
    cur = v;
  endtask
`endif

  task automatic test_default_size;
    int i, guard, n, r, c, maxr, maxw;
    logic take;
    for (int k = 0; k < 72; k++) dvec[k] = {$urandom, $urandom};
    i = 0;
    guard = 0;
    while (i < 72 && guard < 200) begin
      in_valid_d = 1'b1;
      in_data    = dvec[i];
      take       = d_in_ready;
      tick();
      guard++;
      if (take) i++;
    end
    in_valid_d = 1'b0;
    checks++;
    if (i != 72 || guard != 72) begin
      errors++;
      $display("FAIL default_load: %0d words in %0d cycles, required 72 in 72", i, guard);
    end
    guard = 0;
    while (!d_out_valid && guard < 8) begin
      tick();
      guard++;
    end
    n = 0;
    maxr = 0;
    maxw = 0;
    while (d_out_valid && n < 6000) begin
      r = n / 72;
      c = n % 72;
      checks++;
      if ({d_a_out, d_w_out, d_row_idx, d_sof, d_eof} !==
          {dvec[c], 8'((r * c * 8) % 192), 8'(r), c == 0, c == 71}) begin
        errors++;
        $display("FAIL default_elem r=%0d c=%0d: a=%h w=%0d row=%0d sof=%b eof=%b, required a=%h w=%0d",
                 r, c, d_a_out, d_w_out, d_row_idx, d_sof, d_eof, dvec[c], (r * c * 8) % 192);
      end
      if (int'(d_row_idx) > maxr) maxr = int'(d_row_idx);
      if (int'(d_w_out) > maxw) maxw = int'(d_w_out);
      n++;
      tick();
    end
    checks++;
    if (n != 5184) begin
      errors++;
      $display("FAIL default_contiguous: %0d valid cycles, required 5184", n);
    end
    checks++;
    if (maxr != 71) begin
      errors++;
      $display("FAIL default_row_max: %0d, required 71", maxr);
    end
    checks++;
    if (maxw >= 192) begin
      errors++;
      $display("FAIL default_w_range: max w %0d, required < 192", maxw);
    end
    checks++;
    if ({d_done, d_in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL default_done: done/in_ready=%b, required 11", {d_done, d_in_ready});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_throttle();
    test_random();
    test_reset_mid();
`ifdef ROWSTREAM_REPLAY_EN
    test_replay();
`endif
    test_default_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
